// File: rtl/sdr_req_arbiter.sv
// sdr_req_arbiter: round-robin two-requester front end for the SDRAM core request generator
module sdr_req_arbiter #(
  parameter int APP_AW  = 26,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_req_i,
  input  logic [APP_AW-1:0] m0_addr_i,
  input  logic              m0_wr_i,
  input  logic              m1_req_i,
  input  logic [APP_AW-1:0] m1_addr_i,
  input  logic              m1_wr_i,
  output logic              m0_ack_o,
  output logic              m1_ack_o,
  output logic              m0_err_o,
  output logic              m1_err_o,
  output logic              req_o,
  output logic [APP_AW-1:0] req_addr_o,
  output logic              req_wr_o,
  output logic              req_id_o,
  input  logic              req_ack_i,
  output logic              timeout_o
);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       last_id, any, win, hit, miss;
  always_comb begin
    any      = m0_req_i | m1_req_i;
    win      = (m0_req_i & m1_req_i) ? ~last_id : m1_req_i;
    hit      = (state == GRANT) && req_ack_i;
    miss     = (state == GRANT) && !req_ack_i && (cnt == LIMIT);
    state_nx = (state == IDLE)  ? (any ? GRANT : IDLE) :
               (state == GRANT) ? ((hit | miss) ? DONE : GRANT) : IDLE;
  end
  assign req_o = (state == GRANT);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  // ack wins over a coincident timeout because miss requires req_ack_i low
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      req_addr_o <= '0;
      req_wr_o   <= 1'b0;
      req_id_o   <= 1'b0;
      last_id    <= 1'b1;
      cnt        <= '0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        req_addr_o <= win ? m1_addr_i : m0_addr_i;
        req_wr_o   <= win ? m1_wr_i : m0_wr_i;
        req_id_o   <= win;
        last_id    <= win;
        cnt        <= '0;
      end else if (state == GRANT && !req_ack_i) begin
        cnt <= cnt + 8'd1;
      end
      m0_ack_o  <= hit & ~req_id_o;
      m1_ack_o  <= hit & req_id_o;
      m0_err_o  <= miss & ~req_id_o;
      m1_err_o  <= miss & req_id_o;
      timeout_o <= timeout_o | miss;
    end
endmodule

// File: tb/tb_sdr_req_arbiter.sv
// tb_sdr_req_arbiter: randomized transactions against a transaction-level arbiter model
module tb_sdr_req_arbiter;
  localparam int AW = 26;
  localparam int TO = 4;
  logic          clk = 1'b0, rst = 1'b1;
  logic          m0_req_i = 0, m1_req_i = 0, m0_wr_i = 0, m1_wr_i = 0, req_ack_i = 0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, req_o, req_wr_o, req_id_o, timeout_o;
  logic [AW-1:0] req_addr_o;
  int            checks = 0, errors = 0;
  bit            last = 1'b1, sticky = 1'b0;
  bit            p[2], w[2];
  logic [AW-1:0] a[2];

  sdr_req_arbiter #(.APP_AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wr_i(m0_wr_i),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wr_i(m1_wr_i),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o), .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .req_o(req_o), .req_addr_o(req_addr_o), .req_wr_o(req_wr_o), .req_id_o(req_id_o),
    .req_ack_i(req_ack_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    m0_req_i = p[0]; m0_addr_i = a[0]; m0_wr_i = w[0];
    m1_req_i = p[1]; m1_addr_i = a[1]; m1_wr_i = w[1];
  endtask

  task automatic refill();
    for (int i = 0; i < 2; i++)
      if (!p[i] && $urandom_range(0, 2) != 0) begin
        p[i] = 1'b1;
        a[i] = AW'($urandom);
        w[i] = 1'($urandom);
      end
    drive();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, req_o, 0);
    check({tag, "_pulses"}, {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, 0);
    check({tag, "_timeout"}, timeout_o, sticky);
  endtask

  // caller is #1 past a rising edge with the DUT in IDLE
  task automatic run(input int n);
    bit win, ok;
    int d, g;
    logic [AW-1:0] ea;
    bit ew;
    for (int t = 0; t < n; t++) begin
      drive();
      if (!p[0] && !p[1]) begin
        @(negedge clk); check_quiet("idle_none");
        @(posedge clk); #1; refill();
        continue;
      end
      win = (p[0] && p[1]) ? !last : p[1];
      ea = a[win]; ew = w[win];
      d = $urandom_range(0, TO + 1);
      g = (d < TO) ? d + 1 : TO;
      ok = (d < TO);
      @(negedge clk); check_quiet("idle");
      @(posedge clk); last = win;
      for (int k = 0; k < g; k++) begin
        #1 req_ack_i = (k == d);
        if (win) m1_addr_i = AW'($urandom); else m0_addr_i = AW'($urandom);
        @(negedge clk);
        check("grant_req", req_o, 1);
        check("grant_addr", req_addr_o, ea);
        check("grant_wr", req_wr_o, ew);
        check("grant_id", req_id_o, win);
        @(posedge clk);
      end
      #1 req_ack_i = 1'b0;
      p[win] = 1'b0;
      drive();
      if (!ok) sticky = 1'b1;
      @(negedge clk);
      check("done_req", req_o, 0);
      check("done_ack", {m1_ack_o, m0_ack_o}, ok ? (32'd1 << win) : 32'd0);
      check("done_err", {m1_err_o, m0_err_o}, ok ? 32'd0 : (32'd1 << win));
      check("done_timeout", timeout_o, sticky);
      @(posedge clk); #1;
      refill();
    end
  endtask

  initial begin
    #1;
    check("rst_req", req_o, 0);
    check("rst_addr", req_addr_o, 0);
    check("rst_wr", req_wr_o, 0);
    check("rst_id", req_id_o, 0);
    check("rst_pulses", {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, 0);
    check("rst_timeout", timeout_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    p[0] = 1; a[0] = AW'(32'h0000123); w[0] = 0;
    p[1] = 1; a[1] = AW'(32'h0000456); w[1] = 1;
    run(60);
    p[0] = 1; p[1] = 0; a[0] = AW'($urandom); w[0] = 1;
    drive();
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("midrst_req", req_o, 0);
    check("midrst_addr", req_addr_o, 0);
    check("midrst_id", req_id_o, 0);
    check("midrst_pulses", {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, 0);
    check("midrst_timeout", timeout_o, 0);
    p[0] = 0; drive();
    @(posedge clk); #1 rst = 1'b0;
    last = 1'b1; sticky = 1'b0;
    @(negedge clk); check_quiet("post_rst");
    @(posedge clk); #1;
    p[0] = 1; p[1] = 1; a[0] = AW'($urandom); a[1] = AW'($urandom);
    run(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdr_req_arbiter.md
SDR_REQ_ARBITER -- requirements
Module: sdr_req_arbiter

Interface
REQ-001 SHALL have parameter APP_AW, default 26, giving the width of the application address.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for req_ack_i (range 1..255).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports m0_req_i and m1_req_i, input, 1 bit each: requester N wants one SDRAM access; held until ack or err.
REQ-006 SHALL have ports m0_addr_i and m1_addr_i, input, APP_AW bits each: access address; stable while mN_req_i=1.
REQ-007 SHALL have ports m0_wr_i and m1_wr_i, input, 1 bit each: 1=write, 0=read; stable while mN_req_i=1.
REQ-008 SHALL have ports m0_ack_o and m1_ack_o, output, 1 bit each: one-cycle pulse meaning the core accepted requester N's access.
REQ-009 SHALL have ports m0_err_o and m1_err_o, output, 1 bit each: one-cycle pulse meaning requester N's access timed out.
REQ-010 SHALL have port req_o, output, 1 bit: request to the core request generator.
REQ-011 SHALL have port req_addr_o, output, APP_AW bits: registered address of the granted requester.
REQ-012 SHALL have port req_wr_o, output, 1 bit: registered write flag of the granted requester.
REQ-013 SHALL have port req_id_o, output, 1 bit: index of the granted requester.
REQ-014 SHALL have port req_ack_i, input, 1 bit: core accepts the request (bank FIFO ready); sampled only while req_o=1.
REQ-015 SHALL have port timeout_o, output, 1 bit: sticky flag, set on any timeout.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, DONE.
REQ-017 IDLE: when at least one mN_req_i=1, SHALL select a winner, register its addr/wr/id into req_addr_o/req_wr_o/req_id_o, and enter GRANT on the next edge.
REQ-018 Winner selection SHALL be round-robin: 1-bit pointer last_id; with both requesting, winner = ~last_id; with one requesting, that one wins regardless of pointer.
REQ-019 last_id SHALL update to the winner on every IDLE->GRANT transition; its reset value is 1, so m0 wins the first simultaneous request.
REQ-020 GRANT: req_o=1; req_addr_o/req_wr_o/req_id_o SHALL stay constant; requester inputs are ignored.
REQ-021 GRANT: req_ack_i=1 at an edge SHALL cause DONE with ack=1, and req_o=0 from that edge on.
REQ-022 GRANT SHALL run an 8-bit wait counter, cleared on GRANT entry and incremented each GRANT cycle with req_ack_i=0.
REQ-023 When the counter equals TIMEOUT-1 and req_ack_i=0, the FSM SHALL enter DONE with err=1 and set timeout_o.
REQ-024 If req_ack_i=1 in the same cycle the timeout is reached, ack SHALL take precedence and no err is raised.
REQ-025 DONE: exactly one of mN_ack_o or mN_err_o (N=req_id_o) SHALL be 1 for this single cycle; then the FSM returns to IDLE.
REQ-026 A requester SHALL deassert mN_req_i on the edge after its ack/err; IDLE arbitration therefore starts no sooner than one cycle after DONE.
REQ-027 Back-to-back requests from one requester with the other idle SHALL all be served: 3 cycles per access when req_ack_i is immediate.
REQ-028 ack/err outputs SHALL be driven from registers, with no combinational path from any input.
REQ-029 req_o SHALL be asserted only in GRANT; at most one mN_ack_o/mN_err_o SHALL be high in any cycle.

Reset
REQ-030 While wb_rst_i=1 (asynchronously): state=IDLE, req_o=0, req_addr_o=0, req_wr_o=0, req_id_o=0, all ack/err=0, counter=0, last_id=1, timeout_o=0.
REQ-031 Reset asserted in GRANT or DONE SHALL abort the access with no ack/err pulse; operation resumes on the first edge after release.

Verification
REQ-032 Single read: m0_req_i=1, addr=0x0000123, wr=0, req_ack_i=1 on the 2nd GRANT cycle -> req_o high 2 cycles with addr 0x0000123, then m0_ack_o pulses once.
REQ-033 Simultaneous requests after reset, req_ack_i tied 1 -> m0 served first, then m1; with both held, grants alternate 0,1,0,1.
REQ-034 Timeout: TIMEOUT=4, m1 write, req_ack_i=0 -> req_o high 4 cycles, m1_err_o pulses, timeout_o stays 1 until reset.
REQ-035 req_ack_i=1 exactly on the TIMEOUT-th cycle -> ack pulse, no err, timeout_o=0.
REQ-036 Reset asserted mid-GRANT -> req_o drops immediately, no ack/err; next request after release is granted normally.
REQ-037 Input change during GRANT (m0_addr_i altered) -> req_addr_o keeps the latched value.
